// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7_frame_gen display feeder:
// FSM states, active-low hex segment table and small helpers.
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      WAIT_BUSY,
      WAIT_DONE
   } state_e;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Index n holds the {dp,g..a} pattern for hex digit n, dp dark.
   localparam logic [15:0][7:0] SEG_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [7:0] seg_encode(input logic [3:0] nib, input logic dp);
      return {~dp, SEG_TABLE[nib][6:0]};
   endfunction

endpackage

// File: rtl/seg7_frame_gen_if.sv
// Bus-write and serializer-side signals of seg7_frame_gen.
// slave = the frame generator, master = CPU bus + serializer side.
interface seg7_frame_gen_if #(
   parameter int unsigned DIGITS = 8
);

   logic                  wr_en;
   logic [31:0]           wr_data;
   logic [DIGITS-1:0]     wr_dp;
   logic                  sen;
   logic [DIGITS*8-1:0]   frame;
   logic                  sync;
   logic                  busy;
   logic                  err;

   modport master (
      output wr_en, wr_data, wr_dp, sen,
      input  frame, sync, busy, err
   );

   modport slave (
      input  wr_en, wr_data, wr_dp, sen,
      output frame, sync, busy, err
   );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble + decimal point to active-low 7-segment byte.
// blank_i darkens all segments while still showing the decimal point.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       dp_i,
   input  logic       blank_i,
   output logic [7:0] seg_o_c
);

   always_comb begin
      if (blank_i) begin
         seg_o_c = {~dp_i, SEG_BLANK[6:0]};
      end else begin
         seg_o_c = seg_encode(nib_i, dp_i);
      end
   end

endmodule

// File: rtl/seg7_frame_gen.sv
// Captures a hex value + dp mask, decodes it to a 7-segment frame and hands it
// to an external serializer via sync/sen. Optional macro: SEG7_BLANK_LEADING_EN.
module seg7_frame_gen
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS       = 8,
   parameter int unsigned SYNC_HOLD    = 2,
   parameter int unsigned BUSY_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   seg7_frame_gen_if.slave  bus
);

   localparam int unsigned FRAME_W = DIGITS * 8;
   localparam int unsigned VAL_W   = DIGITS * 4;
   localparam int unsigned CNT_MAX = max_u(SYNC_HOLD, BUSY_TIMEOUT);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(SYNC_HOLD - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(BUSY_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     cnt_inc;
   logic [31:0]          val_q, val_d;
   logic [DIGITS-1:0]    dp_q, dp_d;
   logic                 pending_q, pending_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic                 sync_q, sync_d;
   logic                 busy_q, busy_d;
   logic                 err_q, err_d;

   logic [VAL_W-1:0]     nib_all;
   logic [DIGITS-1:0]    blank_c;
   logic [FRAME_W-1:0]   decoded_c;

   assign nib_all = VAL_W'(val_q);

`ifdef SEG7_BLANK_LEADING_EN
   // lead_zero[i]: every nibble from digit i up to the MSB digit is zero.
   logic [DIGITS:1] lead_zero;
   assign lead_zero[DIGITS] = 1'b1;
   assign blank_c[0]        = 1'b0;
   for (genvar i = 1; i < DIGITS; i++) begin : g_lead
      assign lead_zero[i] = lead_zero[i+1] && (nib_all[4*i +: 4] == 4'h0);
      assign blank_c[i]   = lead_zero[i];
   end
`else
   assign blank_c = '0;
`endif

   for (genvar i = 0; i < DIGITS; i++) begin : g_dec
      seg7_hex_decode u_dec (
         .nib_i   (nib_all[4*i +: 4]),
         .dp_i    (dp_q[i]),
         .blank_i (blank_c[i]),
         .seg_o_c (decoded_c[8*i +: 8])
      );
   end

   assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

   // Shadow capture, hand-off FSM and registered output values.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      val_d     = val_q;
      dp_d      = dp_q;
      pending_d = pending_q;
      frame_d   = frame_q;
      err_d     = err_q;

      if (bus.wr_en) begin
         val_d     = bus.wr_data;
         dp_d      = bus.wr_dp;
         pending_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (pending_q && bus.sen) begin
               frame_d   = decoded_c;
               pending_d = bus.wr_en;
               cnt_d     = '0;
               state_d   = SYNC;
            end
         end
         SYNC: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = WAIT_BUSY;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         WAIT_BUSY: begin
            if (!bus.sen) begin
               cnt_d   = '0;
               state_d = WAIT_DONE;
            end else if (cnt_inc == TIMEOUT_CNT) begin
               cnt_d   = '0;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         WAIT_DONE: begin
            if (bus.sen) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      sync_d = (state_d == SYNC);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         val_q     <= '0;
         dp_q      <= '0;
         pending_q <= 1'b0;
         frame_q   <= '1;
         sync_q    <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         val_q     <= val_d;
         dp_q      <= dp_d;
         pending_q <= pending_d;
         frame_q   <= frame_d;
         sync_q    <= sync_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   assign bus.frame = frame_q;
   assign bus.sync  = sync_q;
   assign bus.busy  = busy_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_seg7_frame_gen.sv
// Scoreboard bench for seg7_frame_gen: expected frames are queued at write
// time from an independent decode model and compared when sync rises.
module tb_seg7_frame_gen;

   localparam int unsigned DIGITS       = 8;
   localparam int unsigned SYNC_HOLD    = 2;
   localparam int unsigned BUSY_TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [63:0] exp_q[$];

   seg7_frame_gen_if #(.DIGITS(DIGITS)) bus_if ();

   seg7_frame_gen #(
      .DIGITS       (DIGITS),
      .SYNC_HOLD    (SYNC_HOLD),
      .BUSY_TIMEOUT (BUSY_TIMEOUT)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
         4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
         4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
         4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
      endcase
   endfunction

   function automatic logic [63:0] model_frame(input logic [31:0] v, input logic [7:0] dp);
      logic [63:0] f;
      logic [7:0]  sb;
      logic [3:0]  nib;
      bit          lead;
      f    = '1;
      lead = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         nib  = v[4*i +: 4];
         lead = lead && (nib == 4'h0) && (i != 0);
`ifdef SEG7_BLANK_LEADING_EN
         sb = lead ? 8'hFF : hex_seg(nib);
`else
         sb = hex_seg(nib);
`endif
         if (dp[i]) sb[7] = 1'b0;
         f[8*i +: 8] = sb;
      end
      return f;
   endfunction

   task automatic do_write(input logic [31:0] v, input logic [7:0] dp, input bit push);
      bus_if.wr_en   = 1'b1;
      bus_if.wr_data = v;
      bus_if.wr_dp   = dp;
      if (push) exp_q.push_back(model_frame(v, dp));
      @(negedge clk);
      bus_if.wr_en = 1'b0;
   endtask

   task automatic wait_sync(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk);
         if (bus_if.sync === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_idle(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk);
         if (bus_if.busy === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      bus_if.wr_en   = 1'b0;
      bus_if.wr_data = '0;
      bus_if.wr_dp   = '0;
      bus_if.sen     = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus_if.frame !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL reset_frame: got %h expected %h", bus_if.frame, 64'hFFFF_FFFF_FFFF_FFFF); end
      checks++; if (bus_if.sync !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b expected 0", bus_if.sync); end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
      checks++; if (bus_if.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus_if.err); end
   endtask

   task automatic test_basic();
      logic [63:0] exp;
      bit stable;
      bus_if.sen = 1'b1;
      do_write(32'h12345678, 8'h00, 1'b1);
      checks++; if (bus_if.sync !== 1'b0) begin errors++; $display("FAIL basic_latency_early: sync got %b expected 0", bus_if.sync); end
      @(negedge clk);
      checks++; if (bus_if.sync !== 1'b1) begin errors++; $display("FAIL basic_sync_rise: got %b expected 1", bus_if.sync); end
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      checks++; if (bus_if.frame !== exp) begin errors++; $display("FAIL basic_frame: got %h expected %h", bus_if.frame, exp); end
      checks++; if (bus_if.frame !== 64'hF9A4B0999282F880) begin errors++; $display("FAIL basic_frame_literal: got %h expected %h", bus_if.frame, 64'hF9A4B0999282F880); end
      bus_if.sen = 1'b0;
      @(negedge clk);
      checks++; if (bus_if.sync !== 1'b1) begin errors++; $display("FAIL basic_sync_hold: got %b expected 1", bus_if.sync); end
      @(negedge clk);
      checks++; if (bus_if.sync !== 1'b0 || bus_if.busy !== 1'b1) begin errors++; $display("FAIL basic_sync_fall: sync/busy got %b%b expected 01", bus_if.sync, bus_if.busy); end
      stable = 1'b1;
      repeat (63) begin
         @(negedge clk);
         if (bus_if.frame !== exp || bus_if.sync !== 1'b0 || bus_if.busy !== 1'b1) stable = 1'b0;
      end
      checks++; if (!stable) begin errors++; $display("FAIL basic_shift_stable: got unstable frame/sync/busy expected steady"); end
      bus_if.sen = 1'b1;
      @(negedge clk);
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_drop: got %b expected 0", bus_if.busy); end
   endtask

   task automatic test_dp_hex();
      logic [63:0] exp;
      bit ok;
      do_write(32'hABCDEF01, 8'h01, 1'b1);
      wait_sync(4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL dp_sync_timeout: got no sync expected sync"); end
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      checks++; if (bus_if.frame !== exp) begin errors++; $display("FAIL dp_frame: got %h expected %h", bus_if.frame, exp); end
      checks++; if (bus_if.frame !== 64'h8883C6A1868EC079) begin errors++; $display("FAIL dp_frame_literal: got %h expected %h", bus_if.frame, 64'h8883C6A1868EC079); end
      bus_if.sen = 1'b0;
      repeat (10) @(negedge clk);
      bus_if.sen = 1'b1;
      wait_idle(4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL dp_idle_timeout: busy got 1 expected 0"); end
   endtask

   task automatic test_last_write_wins();
      logic [63:0] exp;
      logic [63:0] lit;
      bit ok;
`ifdef SEG7_BLANK_LEADING_EN
      lit = 64'hFFFFFFFFFFFF92C0;
`else
      lit = 64'hC0C0C0C0C0C092C0;
`endif
      bus_if.sen = 1'b0;
      do_write(32'h89AB0000, 8'hFF, 1'b0);
      do_write(32'h00000050, 8'h00, 1'b1);
      repeat (3) @(negedge clk);
      checks++; if (bus_if.busy !== 1'b0 || bus_if.sync !== 1'b0) begin errors++; $display("FAIL lww_hold_idle: busy/sync got %b%b expected 00", bus_if.busy, bus_if.sync); end
      bus_if.sen = 1'b1;
      wait_sync(4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL lww_sync_timeout: got no sync expected sync"); end
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      checks++; if (bus_if.frame !== exp) begin errors++; $display("FAIL lww_frame: got %h expected %h", bus_if.frame, exp); end
      checks++; if (bus_if.frame !== lit) begin errors++; $display("FAIL lww_frame_literal: got %h expected %h", bus_if.frame, lit); end
      bus_if.sen = 1'b0;
      repeat (5) @(negedge clk);
      bus_if.sen = 1'b1;
      wait_idle(4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL lww_idle_timeout: busy got 1 expected 0"); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] first, exp;
      int extra;
      bit ok, stable;
      do_write(32'h00000001, 8'h00, 1'b1);
      wait_sync(4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_sync1_timeout: got no sync expected sync"); end
      first = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      checks++; if (bus_if.frame !== first) begin errors++; $display("FAIL b2b_frame1: got %h expected %h", bus_if.frame, first); end
      bus_if.sen = 1'b0;
      repeat (4) @(negedge clk);
      do_write(32'h00000002, 8'h00, 1'b1);
      extra  = 0;
      stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus_if.sync === 1'b1) extra++;
         if (bus_if.frame !== first) stable = 1'b0;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL b2b_early_sync: got %0d syncs expected 0", extra); end
      checks++; if (!stable) begin errors++; $display("FAIL b2b_frame_hold: got changed frame expected %h", first); end
      bus_if.sen = 1'b1;
      wait_sync(4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_sync2_timeout: got no sync expected sync"); end
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      checks++; if (bus_if.frame !== exp) begin errors++; $display("FAIL b2b_frame2: got %h expected %h", bus_if.frame, exp); end
      checks++; if (bus_if.frame[7:0] !== 8'hA4) begin errors++; $display("FAIL b2b_digit0: got %h expected a4", bus_if.frame[7:0]); end
      bus_if.sen = 1'b0;
      repeat (5) @(negedge clk);
      bus_if.sen = 1'b1;
      wait_idle(4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_idle_timeout: busy got 1 expected 0"); end
      extra = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus_if.sync === 1'b1) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL b2b_extra_sync: got %0d syncs expected 0", extra); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_queue_empty: got %0d entries expected 0", exp_q.size()); end
   endtask

   task automatic test_timeout();
      logic [63:0] exp;
      int first_err;
      bit saw_sync;
      bus_if.sen = 1'b1;
      do_write(32'hC0FFEE42, 8'h10, 1'b1);
      exp       = 64'hx;
      first_err = 0;
      saw_sync  = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (bus_if.sync === 1'b1 && !saw_sync) begin
            saw_sync = 1'b1;
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
            checks++; if (bus_if.frame !== exp) begin errors++; $display("FAIL to_frame: got %h expected %h", bus_if.frame, exp); end
         end
         if (bus_if.err === 1'b1 && first_err == 0) first_err = k;
      end
      checks++; if (!saw_sync) begin errors++; $display("FAIL to_sync_seen: got no sync expected sync"); end
      checks++; if (first_err != int'(1 + SYNC_HOLD + BUSY_TIMEOUT)) begin errors++; $display("FAIL to_err_time: got cycle %0d expected %0d", first_err, 1 + SYNC_HOLD + BUSY_TIMEOUT); end
      checks++; if (bus_if.err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b expected 1", bus_if.err); end
      checks++; if (bus_if.busy !== 1'b0 || bus_if.sync !== 1'b0) begin errors++; $display("FAIL to_back_idle: busy/sync got %b%b expected 00", bus_if.busy, bus_if.sync); end
      checks++; if (bus_if.frame !== exp) begin errors++; $display("FAIL to_frame_kept: got %h expected %h", bus_if.frame, exp); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] exp;
      bit ok;
      bus_if.sen = 1'b1;
      do_write(32'h0000BEEF, 8'h00, 1'b1);
      wait_sync(4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rm_sync_timeout: got no sync expected sync"); end
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      checks++; if (bus_if.frame !== exp) begin errors++; $display("FAIL rm_frame: got %h expected %h", bus_if.frame, exp); end
      bus_if.sen = 1'b0;
      @(negedge clk);
      #3 rst = 1'b1;
      #1;
      checks++; if (bus_if.frame !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rm_frame_dark: got %h expected all ones", bus_if.frame); end
      checks++; if (bus_if.busy !== 1'b0 || bus_if.sync !== 1'b0 || bus_if.err !== 1'b0) begin errors++; $display("FAIL rm_flags: busy/sync/err got %b%b%b expected 000", bus_if.busy, bus_if.sync, bus_if.err); end
      @(negedge clk);
      rst        = 1'b0;
      bus_if.sen = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL rm_no_pending: busy got %b expected 0", bus_if.busy); end
      do_write(32'h12345678, 8'h80, 1'b1);
      wait_sync(4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rm_resync_timeout: got no sync expected sync"); end
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      checks++; if (bus_if.frame !== exp) begin errors++; $display("FAIL rm_frame_after: got %h expected %h", bus_if.frame, exp); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_dp_hex();
      test_last_write_wins();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
